// File: rtl/player_bullet_if.sv
// player_bullet_if: player/collision-side signals into the bullet engine and
// bullet slot state back out to the collision unit and sprite renderer.
interface player_bullet_if #(
  parameter int unsigned MAX_BULLETS = 2
) ();

  logic                          shoot_bullet;
  logic [9:0]                    player_X;
  logic [MAX_BULLETS-1:0]        hit;
  logic [10*MAX_BULLETS-1:0]     bullet_X;
  logic [10*MAX_BULLETS-1:0]     bullet_Y;
  logic [MAX_BULLETS-1:0]        bullet_active;
  logic                          fired;

  // Player stage / collision unit side
  modport master (
    output shoot_bullet, player_X, hit,
    input  bullet_X, bullet_Y, bullet_active, fired
  );

  // Bullet engine side
  modport slave (
    input  shoot_bullet, player_X, hit,
    output bullet_X, bullet_Y, bullet_active, fired
  );

endinterface

// File: rtl/player_bullet.sv
// player_bullet: player-projectile engine. Spawns bullets at the cannon,
// advances them upward once per frame and retires them at the top or on hit.
// Optional macro PLAYER_BULLET_AUTOFIRE_EN: when defined, holding fire
// auto-repeats; otherwise only a rising edge of shoot_bullet fires.
module player_bullet #(
  parameter int unsigned MAX_BULLETS = 2,
  parameter logic [9:0]  SPAWN_Y     = 10'd440,
  parameter logic [9:0]  Y_MIN       = 10'd0,
  parameter logic [9:0]  BULLET_STEP = 10'd4,
  parameter logic [3:0]  COOLDOWN    = 4'd8
) (
  input  logic           frame_clk,
  input  logic           Reset_n,
  player_bullet_if.slave bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FLY  = 1'b1
  } slot_state_t;

  // A flying bullet below this row retires instead of moving, so Y never wraps
  localparam logic [9:0] RETIRE_Y = 10'(Y_MIN + BULLET_STEP);

  slot_state_t            r_state     [MAX_BULLETS];
  slot_state_t            w_state_nxt [MAX_BULLETS];
  logic [9:0]             r_x         [MAX_BULLETS];
  logic [9:0]             w_x_nxt     [MAX_BULLETS];
  logic [9:0]             r_y         [MAX_BULLETS];
  logic [9:0]             w_y_nxt     [MAX_BULLETS];
  logic [3:0]             r_cooldown;
  logic [3:0]             w_cooldown_nxt;
  logic                   r_spawned;
  logic                   r_fired;
  logic                   w_req;
  logic                   w_spawn;
  logic                   w_any_idle;
  logic [MAX_BULLETS-1:0] w_spawn_sel;

`ifdef PLAYER_BULLET_AUTOFIRE_EN
  // Level-sensitive fire request: holding fire repeats at the cooldown rate
  assign w_req = bus.shoot_bullet;
`else
  logic r_shoot_prev;

  // Previous fire level for rising-edge detection
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_shoot_prev <= 1'b0;
    end else begin
      r_shoot_prev <= bus.shoot_bullet;
    end
  end

  assign w_req = bus.shoot_bullet & ~r_shoot_prev;
`endif

  // Pick the lowest-indexed slot that is idle in the registered state
  always_comb begin
    w_spawn_sel = '0;
    w_any_idle  = 1'b0;
    for (int i = 0; i < MAX_BULLETS; i++) begin
      if (!w_any_idle && (r_state[i] == S_IDLE)) begin
        w_spawn_sel[i] = 1'b1;
        w_any_idle     = 1'b1;
      end
    end
  end

  assign w_spawn = w_req & (r_cooldown == 4'd0) & w_any_idle;

  // Slot state register plus cooldown and fired pipeline
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < MAX_BULLETS; i++) begin
        r_state[i] <= S_IDLE;
        r_x[i]     <= 10'd0;
        r_y[i]     <= 10'd0;
      end
      r_cooldown <= 4'd0;
      r_spawned  <= 1'b0;
      r_fired    <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_BULLETS; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_x[i]     <= w_x_nxt[i];
        r_y[i]     <= w_y_nxt[i];
      end
      r_cooldown <= w_cooldown_nxt;
      r_spawned  <= w_spawn;
      r_fired    <= r_spawned;
    end
  end

  // Per-slot next state: hit beats retire beats move; idle slots accept spawns
  always_comb begin
    for (int i = 0; i < MAX_BULLETS; i++) begin
      w_state_nxt[i] = r_state[i];
      w_x_nxt[i]     = r_x[i];
      w_y_nxt[i]     = r_y[i];
      case (r_state[i])
        S_FLY: begin
          if (bus.hit[i]) begin
            w_state_nxt[i] = S_IDLE;
          end else if (r_y[i] < RETIRE_Y) begin
            w_state_nxt[i] = S_IDLE;
          end else begin
            w_y_nxt[i] = 10'(r_y[i] - BULLET_STEP);
          end
        end
        default: begin
          if (w_spawn && w_spawn_sel[i]) begin
            w_state_nxt[i] = S_FLY;
            w_x_nxt[i]     = bus.player_X;
            w_y_nxt[i]     = SPAWN_Y;
          end
        end
      endcase
    end
  end

  // Cooldown loads on spawn, otherwise counts down and saturates at zero
  always_comb begin
    w_cooldown_nxt = r_cooldown;
    if (w_spawn) begin
      w_cooldown_nxt = COOLDOWN;
    end else if (r_cooldown != 4'd0) begin
      w_cooldown_nxt = 4'(r_cooldown - 4'd1);
    end
  end

  // Outputs are straight copies of registered slot and control state
  always_comb begin
    bus.bullet_X      = '0;
    bus.bullet_Y      = '0;
    bus.bullet_active = '0;
    for (int i = 0; i < MAX_BULLETS; i++) begin
      bus.bullet_X[10*i +: 10] = r_x[i];
      bus.bullet_Y[10*i +: 10] = r_y[i];
      bus.bullet_active[i]     = (r_state[i] == S_FLY);
    end
    bus.fired = r_fired;
  end

endmodule

// File: tb/tb_player_bullet.sv
// tb_player_bullet: directed checks of the player bullet engine.
module tb_player_bullet;

  logic frame_clk = 1'b0;
  logic Reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   fired_cnt;

  player_bullet_if #(.MAX_BULLETS(2)) bus  ();
  player_bullet_if #(.MAX_BULLETS(1)) bus2 ();

  player_bullet #(.MAX_BULLETS(2)) u_dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .bus       (bus)
  );

  player_bullet #(
    .MAX_BULLETS (1),
    .SPAWN_Y     (10'd8),
    .BULLET_STEP (10'd4)
  ) u_dut_short (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .bus       (bus2)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear_inputs();
    bus.shoot_bullet  = 1'b0;
    bus.player_X      = 10'd0;
    bus.hit           = 2'b00;
    bus2.shoot_bullet = 1'b0;
    bus2.player_X     = 10'd0;
    bus2.hit          = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    Reset_n = 1'b0;
    ticks(2);
    Reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    clear_inputs();
    Reset_n = 1'b0;
    ticks(2);
    check("rst_active", 32'(bus.bullet_active), 0);
    check("rst_x",      32'(bus.bullet_X), 0);
    check("rst_y",      32'(bus.bullet_Y), 0);
    check("rst_fired",  32'(bus.fired), 0);
    Reset_n = 1'b1;

    // Single shot, plus a press during cooldown that must be dropped
    bus.player_X = 10'd320;
    bus.shoot_bullet = 1'b1;
    tick();                                            // e0 spawn
    check("ss_active_e0", 32'(bus.bullet_active), 1);
    check("ss_x_e0",      32'(bus.bullet_X[9:0]), 320);
    check("ss_y_e0",      32'(bus.bullet_Y[9:0]), 440);
    check("ss_fired_e0",  32'(bus.fired), 0);
    bus.shoot_bullet = 1'b0;
    tick();                                            // e1
    check("ss_fired_e1",  32'(bus.fired), 1);
    check("ss_y_e1",      32'(bus.bullet_Y[9:0]), 436);
    bus.shoot_bullet = 1'b1;
    tick();                                            // e2 denied by cooldown
    check("ss_fired_e2",  32'(bus.fired), 0);
    check("cd_deny_e2",   32'(bus.bullet_active), 1);
    bus.shoot_bullet = 1'b0;
    ticks(8);                                          // e10
    check("ss_y_e10",     32'(bus.bullet_Y[9:0]), 400);
    check("cd_noqueue",   32'(bus.bullet_active), 1);
    ticks(100);                                        // e110
    check("ss_y_e110",    32'(bus.bullet_Y[9:0]), 0);
    check("ss_act_e110",  32'(bus.bullet_active), 1);
    tick();                                            // e111 retire
    check("ss_act_e111",  32'(bus.bullet_active), 0);

    // Hit kill
    do_reset();
    bus.player_X = 10'd200;
    bus.shoot_bullet = 1'b1;
    tick();                                            // e0 slot0
    bus.shoot_bullet = 1'b0;
    ticks(8);                                          // e8
    bus.player_X = 10'd300;
    bus.shoot_bullet = 1'b1;
    tick();                                            // e9 slot1
    bus.shoot_bullet = 1'b0;
    check("hk_active_e9", 32'(bus.bullet_active), 3);
    check("hk_x1_e9",     32'(bus.bullet_X[19:10]), 300);
    check("hk_y0_e9",     32'(bus.bullet_Y[9:0]), 404);
    ticks(26);                                         // e35
    check("hk_y0_e35",    32'(bus.bullet_Y[9:0]), 300);
    check("hk_y1_e35",    32'(bus.bullet_Y[19:10]), 336);
    bus.hit = 2'b01;
    tick();                                            // e36 kill slot0
    check("hk_active_e36", 32'(bus.bullet_active), 2);
    check("hk_y0_hold",    32'(bus.bullet_Y[9:0]), 300);
    check("hk_x0_hold",    32'(bus.bullet_X[9:0]), 200);
    check("hk_y1_e36",     32'(bus.bullet_Y[19:10]), 332);
    tick();                                            // e37 hit on idle slot
    check("hk_idle_act",   32'(bus.bullet_active), 2);
    check("hk_idle_y0",    32'(bus.bullet_Y[9:0]), 300);
    check("hk_y1_e37",     32'(bus.bullet_Y[19:10]), 328);
    bus.hit = 2'b00;

`ifdef PLAYER_BULLET_AUTOFIRE_EN
    // Slot exhaustion under autofire
    do_reset();
    bus.player_X = 10'd10;
    bus.shoot_bullet = 1'b1;
    tick();                                            // e0
    check("af_act_e0",  32'(bus.bullet_active), 1);
    ticks(8);                                          // e8
    check("af_act_e8",  32'(bus.bullet_active), 1);
    tick();                                            // e9
    check("af_act_e9",  32'(bus.bullet_active), 3);
    check("af_x1_e9",   32'(bus.bullet_X[19:10]), 10);
    tick();                                            // e10
    check("af_fired_e10", 32'(bus.fired), 1);
    ticks(9);                                          // e19
    check("af_fired_e19", 32'(bus.fired), 0);
    check("af_act_e19",   32'(bus.bullet_active), 3);
    ticks(91);                                         // e110
    check("af_act_e110",  32'(bus.bullet_active), 3);
    bus.player_X = 10'd77;
    tick();                                            // e111 slot0 retires
    check("af_act_e111",  32'(bus.bullet_active), 2);
    tick();                                            // e112 respawn slot0
    check("af_act_e112",  32'(bus.bullet_active), 3);
    check("af_x0_e112",   32'(bus.bullet_X[9:0]), 77);
    check("af_y0_e112",   32'(bus.bullet_Y[9:0]), 440);
    bus.shoot_bullet = 1'b0;
`else
    // Edge-only firing
    do_reset();
    bus.player_X = 10'd64;
    bus.shoot_bullet = 1'b1;
    tick();                                            // e0
    check("eo_act_e0", 32'(bus.bullet_active), 1);
    fired_cnt = 0;
    for (int k = 0; k < 49; k++) begin                 // e1..e49
      tick();
      if (bus.fired === 1'b1) fired_cnt++;
    end
    check("eo_act_e49", 32'(bus.bullet_active), 1);
    check("eo_fired_cnt", 32'(fired_cnt), 1);
    bus.shoot_bullet = 1'b0;
    tick();                                            // e50
    bus.player_X = 10'd128;
    bus.shoot_bullet = 1'b1;
    tick();                                            // e51 second press
    check("eo_act_e51", 32'(bus.bullet_active), 3);
    check("eo_x1_e51",  32'(bus.bullet_X[19:10]), 128);
    check("eo_y1_e51",  32'(bus.bullet_Y[19:10]), 440);
    check("eo_y0_e51",  32'(bus.bullet_Y[9:0]), 236);
    bus.shoot_bullet = 1'b0;
`endif

    // Retire boundary with SPAWN_Y=8
    do_reset();
    bus2.player_X = 10'd7;
    bus2.shoot_bullet = 1'b1;
    tick();
    check("rb_act_0", 32'(bus2.bullet_active), 1);
    check("rb_y_0",   32'(bus2.bullet_Y), 8);
    bus2.shoot_bullet = 1'b0;
    tick();
    check("rb_y_1",   32'(bus2.bullet_Y), 4);
    tick();
    check("rb_y_2",   32'(bus2.bullet_Y), 0);
    check("rb_act_2", 32'(bus2.bullet_active), 1);
    tick();
    check("rb_act_3", 32'(bus2.bullet_active), 0);
    check("rb_y_3",   32'(bus2.bullet_Y), 0);

    // Reset mid-flight with both slots active and fired high
    do_reset();
    bus.player_X = 10'd200;
    bus.shoot_bullet = 1'b1;
    tick();                                            // e0
    bus.shoot_bullet = 1'b0;
    ticks(8);                                          // e8
    bus.player_X = 10'd300;
    bus.shoot_bullet = 1'b1;
    tick();                                            // e9
    bus.shoot_bullet = 1'b0;
    tick();                                            // e10
    check("mr_fired_pre", 32'(bus.fired), 1);
    check("mr_act_pre",   32'(bus.bullet_active), 3);
    Reset_n = 1'b0;
    #1;
    check("mr_act",   32'(bus.bullet_active), 0);
    check("mr_x",     32'(bus.bullet_X), 0);
    check("mr_y",     32'(bus.bullet_Y), 0);
    check("mr_fired", 32'(bus.fired), 0);
    #1;
    Reset_n = 1'b1;
    bus.player_X = 10'd50;
    bus.shoot_bullet = 1'b1;
    tick();
    check("mr_refire_act", 32'(bus.bullet_active), 1);
    check("mr_refire_x",   32'(bus.bullet_X[9:0]), 50);
    check("mr_refire_y",   32'(bus.bullet_Y[9:0]), 440);
    bus.shoot_bullet = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
